// File: rtl/vga_timing_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_pattern_gen
//  Description : Raster timing generator (blank, sync, DE, x/y, frame marks)
//                with a four-mode RGB test-pattern source and pixel-clock
//                enable division.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_pattern_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CE_DIV   = 1,
  parameter int CNT_W    = 11,
  parameter int GRID_SH  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode,
  output logic             ce_pix,
  output logic             HBlank,
  output logic             VBlank,
  output logic             HSync,
  output logic             VSync,
  output logic             DE,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             frame_start,
  output logic [7:0]       frame_cnt,
  output logic [7:0]       vr,
  output logic [7:0]       vg,
  output logic [7:0]       vb
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DC_W    = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;

  localparam logic [CNT_W-1:0] H_ACT     = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_ACT_END = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] H_SYNC_ST = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_EN = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_ACT     = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_END = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] V_SYNC_ST = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_EN = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
  localparam logic [DC_W-1:0]  DC_LAST   = DC_W'(CE_DIV - 1);
  localparam logic             HS_ON     = (HS_POL != 0);
  localparam logic             VS_ON     = (VS_POL != 0);

  logic [DC_W-1:0]  dc;
  logic [CNT_W-1:0] hc;
  logic [CNT_W-1:0] vc;
  logic [7:0]       fc;
  logic [1:0]       mode_q;
  logic             tick;
  logic             at_origin;
  logic [1:0]       mode_eff;
  logic             h_act;
  logic             v_act;
  logic             hs_act;
  logic             vs_act;
  logic             grid_line;
  logic [2:0]       bar;
  logic [23:0]      rgb_next;

  assign tick = (dc == '0);

  // Pixel colour and window decode for the current counter position
  always_comb begin
    at_origin = (hc == '0) && (vc == '0);
    // A new mode applies from the very first pixel of the frame
    mode_eff  = at_origin ? mode : mode_q;
    h_act     = (hc < H_ACT);
    v_act     = (vc < V_ACT);
    hs_act    = (hc >= H_SYNC_ST) && (hc < H_SYNC_EN);
    vs_act    = (vc >= V_SYNC_ST) && (vc < V_SYNC_EN);
    grid_line = (hc[GRID_SH-1:0] == '0) || (vc[GRID_SH-1:0] == '0) ||
                (hc == H_ACT_END) || (vc == V_ACT_END);
    // Bar boundaries are elaboration-time constants; highest passed bound wins
    bar = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (hc >= CNT_W'(k * H_ACTIVE / 8)) bar = 3'(k);
    end
    case (mode_eff)
      2'd0: begin
        if (grid_line) rgb_next = 24'hFFFFFF;
        else           rgb_next = {(hc[GRID_SH] ? 8'hFF : 8'h00), 8'h00,
                                   (vc[GRID_SH] ? 8'h00 : 8'hFF)};
      end
      2'd1:    rgb_next = {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}};
      2'd2:    rgb_next = (hc[GRID_SH] ^ vc[GRID_SH]) ? 24'hFFFFFF : 24'h000000;
      default: rgb_next = {hc[7:0], hc[7:0], hc[7:0]};
    endcase
    if (!(h_act && v_act)) rgb_next = 24'h000000;
  end

  // Divider, raster counters and registered video outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      dc          <= '0;
      hc          <= '0;
      vc          <= '0;
      fc          <= 8'd0;
      mode_q      <= 2'd0;
      ce_pix      <= 1'b0;
      HBlank      <= 1'b0;
      VBlank      <= 1'b0;
      HSync       <= ~HS_ON;
      VSync       <= ~VS_ON;
      DE          <= 1'b0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
      frame_cnt   <= 8'd0;
      vr          <= 8'd0;
      vg          <= 8'd0;
      vb          <= 8'd0;
    end else begin
      dc          <= (dc == DC_LAST) ? '0 : dc + 1'b1;
      ce_pix      <= tick;
      frame_start <= tick && at_origin;
      if (tick) begin
        HBlank       <= ~h_act;
        VBlank       <= ~v_act;
        HSync        <= hs_act ? HS_ON : ~HS_ON;
        VSync        <= vs_act ? VS_ON : ~VS_ON;
        DE           <= h_act && v_act;
        x            <= hc;
        y            <= vc;
        frame_cnt    <= fc;
        {vr, vg, vb} <= rgb_next;
        if (at_origin) mode_q <= mode;
        if (hc == H_LAST) begin
          hc <= '0;
          if (vc == V_LAST) begin
            vc <= '0;
            fc <= fc + 8'd1;
          end else begin
            vc <= vc + 1'b1;
          end
        end else begin
          hc <= hc + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire
